// File: rtl/ipid_sig_store_cmp.sv
// IP-ID signature store: assembles SIG_W signatures from SLICE_W slices, serves indexed readback, scans a hash one entry per cycle.
// Latency: readback 1 cycle; compare result k+1 cycles after accept on a hit at index k, max(entry_count,1) cycles on a miss.
// Backpressure: cmp_ready is low outside READY or when load_start is asserted; held-off requests are not consumed.
module ipid_sig_store_cmp #(
  parameter int NUM_IDS = 10,
  parameter int SIG_W   = 256,
  parameter int SLICE_W = 16,
  localparam int IDX_W  = (NUM_IDS > 1) ? $clog2(NUM_IDS) : 1,
  localparam int CNT_W  = $clog2(NUM_IDS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               load_end,
  input  logic               slice_valid,
  input  logic [SLICE_W-1:0] slice_data,
  output logic               load_busy,
  output logic               load_done,
  output logic [CNT_W-1:0]   entry_count,
  input  logic               cmp_valid,
  input  logic [SIG_W-1:0]   cmp_hash,
  output logic               cmp_ready,
  output logic               match_valid,
  output logic               match_hit,
  output logic [IDX_W-1:0]   match_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [SIG_W-1:0]   rd_data,
  output logic               err
);

  localparam int SPS  = SIG_W / SLICE_W;
  localparam int SC_W = (SPS > 1) ? $clog2(SPS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, READY, CMP} state_t;

  state_t             state_q, state_d;
  logic [SC_W-1:0]    slice_cnt_q;
  logic [SIG_W-1:0]   asm_q, asm_next;
  logic [CNT_W-1:0]   entry_count_q;
  logic [SIG_W-1:0]   hash_q;
  logic [IDX_W-1:0]   scan_idx_q;
  logic [SIG_W-1:0]   store [NUM_IDS];

  logic last_slice, scan_hit, scan_last;
  logic do_restart, do_abort, do_shift, do_commit;
  logic done_d, err_d, accept, scan_inc, res_vld, res_hit;

  assign load_busy   = (state_q == LOAD);
  assign cmp_ready   = (state_q == READY) && !load_start;
  assign entry_count = entry_count_q;

  always_comb begin
    state_d    = state_q;
    do_restart = 1'b0;
    do_abort   = 1'b0;
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    accept     = 1'b0;
    scan_inc   = 1'b0;
    res_vld    = 1'b0;
    res_hit    = 1'b0;
    // Cast keeps the low SIG_W bits, so SPS==1 degenerates to a plain load.
    asm_next   = SIG_W'({asm_q, slice_data});
    last_slice = (slice_cnt_q == SC_W'(SPS - 1));
    scan_hit   = (entry_count_q != '0) && (store[scan_idx_q] == hash_q);
    scan_last  = (entry_count_q == '0) ||
                 (CNT_W'(scan_idx_q) == entry_count_q - CNT_W'(1));

    if (slice_valid && state_q != LOAD) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          do_restart = 1'b1;
        end
      end
      READY: begin
        if (load_start) begin
          state_d    = LOAD;
          do_restart = 1'b1;
        end else if (cmp_valid) begin
          state_d = CMP;
          accept  = 1'b1;
        end
      end
      LOAD: begin
        if (load_start) begin
          do_restart = 1'b1;
        end else if (load_end) begin
          state_d  = READY;
          done_d   = 1'b1;
          do_abort = 1'b1;
          if (slice_cnt_q != '0) err_d = 1'b1;
        end else if (slice_valid) begin
          do_shift = 1'b1;
          if (last_slice) begin
            do_commit = 1'b1;
            if (entry_count_q == CNT_W'(NUM_IDS - 1)) begin
              done_d  = 1'b1;
              state_d = READY;
            end
          end
        end
      end
      CMP: begin
        if (scan_hit) begin
          res_vld = 1'b1;
          res_hit = 1'b1;
          state_d = READY;
        end else if (scan_last) begin
          res_vld = 1'b1;
          state_d = READY;
        end else begin
          scan_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slice_cnt_q   <= '0;
      asm_q         <= '0;
      entry_count_q <= '0;
      hash_q        <= '0;
      scan_idx_q    <= '0;
      load_done     <= 1'b0;
      err           <= 1'b0;
      match_valid   <= 1'b0;
      match_hit     <= 1'b0;
      match_idx     <= '0;
      rd_data       <= '0;
    end else begin
      state_q     <= state_d;
      load_done   <= done_d;
      err         <= err_d;
      match_valid <= res_vld;
      if (res_vld) begin
        match_hit <= res_hit;
        match_idx <= res_hit ? scan_idx_q : '0;
      end
      // Entries beyond the committed count read as zero.
      rd_data <= (CNT_W'(rd_idx) < entry_count_q) ? store[rd_idx] : '0;

      if (do_restart) begin
        entry_count_q <= '0;
        slice_cnt_q   <= '0;
      end else if (do_abort) begin
        slice_cnt_q <= '0;
      end else if (do_shift) begin
        asm_q <= asm_next;
        if (last_slice) begin
          slice_cnt_q   <= '0;
          entry_count_q <= entry_count_q + CNT_W'(1);
        end else begin
          slice_cnt_q <= slice_cnt_q + SC_W'(1);
        end
      end

      if (accept) begin
        hash_q     <= cmp_hash;
        scan_idx_q <= '0;
      end else if (scan_inc) begin
        scan_idx_q <= scan_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_commit && !rst) store[IDX_W'(entry_count_q)] <= asm_next;
  end

endmodule

// File: tb/tb_ipid_sig_store_cmp.sv
// Randomised self-checking bench for ipid_sig_store_cmp with a queue-free array reference model.
module tb_ipid_sig_store_cmp;
  localparam int NUM_IDS = 10;
  localparam int SIG_W   = 256;
  localparam int SLICE_W = 16;
  localparam int SPS     = SIG_W / SLICE_W;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst, load_start, load_end, slice_valid, cmp_valid;
  logic [SLICE_W-1:0] slice_data;
  logic [SIG_W-1:0]   cmp_hash;
  logic [IDX_W-1:0]   rd_idx;
  logic               load_busy, load_done, cmp_ready, match_valid, match_hit, err;
  logic [CNT_W-1:0]   entry_count;
  logic [IDX_W-1:0]   match_idx;
  logic [SIG_W-1:0]   rd_data;

  ipid_sig_store_cmp #(.NUM_IDS(NUM_IDS), .SIG_W(SIG_W), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
    .slice_valid(slice_valid), .slice_data(slice_data), .load_busy(load_busy),
    .load_done(load_done), .entry_count(entry_count), .cmp_valid(cmp_valid),
    .cmp_hash(cmp_hash), .cmp_ready(cmp_ready), .match_valid(match_valid),
    .match_hit(match_hit), .match_idx(match_idx), .rd_idx(rd_idx),
    .rd_data(rd_data), .err(err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [SIG_W-1:0] model [NUM_IDS];
  int               model_cnt = 0;
  logic [SIG_W-1:0] ld_vals [NUM_IDS];
  int obs_done, obs_err, obs_gap, obs_err_step, obs_done_step;
  logic obs_busy;

  localparam logic [SIG_W-1:0] MISS_HASH =
    256'haa12953e_1c7f40b2_93d6e1a8_5f02c4d7_6b38a9e0_d4c71f25_0e9b3a6c_71085ecd;

  function automatic logic [SIG_W-1:0] rand_sig();
    logic [SIG_W-1:0] v;
    for (int k = 0; k < SIG_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_commit(input int n);
    for (int i = 0; i < n; i++) model[i] = ld_vals[i];
    model_cnt = n;
  endtask

  // Lowest matching index wins; a scan touches one entry per cycle.
  task automatic ref_lookup(input logic [SIG_W-1:0] h, output logic hit,
                            output logic [IDX_W-1:0] idx, output int lat);
    hit = 1'b0; idx = '0; lat = (model_cnt > 0) ? model_cnt : 1;
    for (int i = 0; i < model_cnt; i++)
      if (!hit && model[i] == h) begin hit = 1'b1; idx = IDX_W'(i); lat = i + 1; end
  endtask

  task automatic run_load(input int n_entries, input int extra, input bit send_end);
    int nsl, last_step, steps;
    nsl = n_entries * SPS + extra;
    last_step = send_end ? nsl : nsl - 1;
    steps = last_step + 4;
    obs_done = 0; obs_err = 0; obs_done_step = -1; obs_err_step = -1;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0; obs_busy = load_busy;
    for (int i = 0; i <= steps; i++) begin
      if (load_done) begin obs_done++; obs_done_step = i; end
      if (err) begin obs_err++; obs_err_step = i; end
      slice_valid = 1'b0; load_end = 1'b0;
      if (i < nsl) begin
        slice_valid = 1'b1;
        slice_data  = ld_vals[i / SPS][SIG_W - 1 - (i % SPS) * SLICE_W -: SLICE_W];
      end else if (send_end && i == nsl) begin
        load_end = 1'b1;
      end
      @(negedge clk);
    end
    obs_gap = obs_done_step - last_step;
  endtask

  task automatic run_cmp(input logic [SIG_W-1:0] h, output bit got, output int lat,
                         output logic hit, output logic [IDX_W-1:0] idx,
                         output logic pulse_after, output logic rdy);
    @(negedge clk); cmp_valid = 1'b1; cmp_hash = h;
    #1 rdy = cmp_ready;
    @(negedge clk); cmp_valid = 1'b0;
    got = 1'b0; lat = 0; hit = 1'bx; idx = 'x;
    for (int i = 0; i < NUM_IDS + 5 && !got; i++) begin
      @(negedge clk); lat++;
      if (match_valid) begin got = 1'b1; hit = match_hit; idx = match_idx; end
    end
    @(negedge clk); pulse_after = match_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({load_busy, load_done, cmp_ready, match_valid, match_hit, err} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_flags got %b want 000000",
        {load_busy, load_done, cmp_ready, match_valid, match_hit, err});
    end
    tests_run++;
    if (entry_count !== '0 || match_idx !== '0 || rd_data !== '0) begin
      tests_failed++; $display("FAIL reset_regs cnt=%0d idx=%0d rd=%h want 0", entry_count, match_idx, rd_data);
    end
    rst = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_full_load();
    logic [SIG_W-1:0] exp3;
    exp3 = 256'h0300030103020303030403050306030703080309030a030b030c030d030e030f;
    for (int e = 0; e < NUM_IDS; e++)
      for (int s = 0; s < SPS; s++)
        ld_vals[e][SIG_W - 1 - s * SLICE_W -: SLICE_W] = {8'(e), 8'(s)};
    run_load(NUM_IDS, 0, 1'b0);
    model_commit(NUM_IDS);
    tests_run++;
    if (obs_busy !== 1'b1) begin tests_failed++; $display("FAIL load_busy got %b want 1", obs_busy); end
    tests_run++;
    if (obs_done != 1 || obs_gap != 1) begin
      tests_failed++; $display("FAIL full_load_done pulses=%0d gap=%0d want 1,1", obs_done, obs_gap);
    end
    tests_run++;
    if (entry_count !== CNT_W'(10) || obs_err != 0) begin
      tests_failed++; $display("FAIL full_load_count cnt=%0d err=%0d want 10,0", entry_count, obs_err);
    end
    rd_idx = 4'd3;
    @(negedge clk);
    tests_run++;
    if (rd_data !== exp3) begin tests_failed++; $display("FAIL readback3 got %h want %h", rd_data, exp3); end
  endtask

  task automatic test_cmp_hit_miss();
    bit got; int lat; logic hit, pa, rdy; logic [IDX_W-1:0] idx;
    run_cmp(model[7], got, lat, hit, idx, pa, rdy);
    tests_run++;
    if (!got || lat != 8 || hit !== 1'b1 || idx !== 4'd7 || pa !== 1'b0 || rdy !== 1'b1) begin
      tests_failed++; $display("FAIL cmp_hit7 got=%0d lat=%0d hit=%b idx=%0d after=%b rdy=%b want 1,8,1,7,0,1",
        got, lat, hit, idx, pa, rdy);
    end
    run_cmp(MISS_HASH, got, lat, hit, idx, pa, rdy);
    tests_run++;
    if (!got || lat != 10 || hit !== 1'b0 || idx !== 4'd0) begin
      tests_failed++; $display("FAIL cmp_miss got=%0d lat=%0d hit=%b idx=%0d want 1,10,0,0", got, lat, hit, idx);
    end
  endtask

  task automatic test_duplicates();
    bit got; int lat; logic hit, pa, rdy; logic [IDX_W-1:0] idx;
    for (int e = 0; e < NUM_IDS; e++) ld_vals[e] = rand_sig();
    ld_vals[5] = ld_vals[2];
    run_load(NUM_IDS, 0, 1'b0);
    model_commit(NUM_IDS);
    run_cmp(ld_vals[5], got, lat, hit, idx, pa, rdy);
    tests_run++;
    if (!got || lat != 3 || hit !== 1'b1 || idx !== 4'd2) begin
      tests_failed++; $display("FAIL dup_lowest got=%0d lat=%0d hit=%b idx=%0d want 1,3,1,2", got, lat, hit, idx);
    end
  endtask

  task automatic test_random();
    bit got; int lat, elat, n; logic hit, ehit, pa, rdy; logic [IDX_W-1:0] idx, eidx, r;
    logic [SIG_W-1:0] h, exp_rd;
    for (int round = 0; round < 4; round++) begin
      n = $urandom_range(1, NUM_IDS);
      for (int e = 0; e < NUM_IDS; e++) begin
        ld_vals[e] = rand_sig();
        if (e > 0 && $urandom_range(0, 3) == 0) ld_vals[e] = ld_vals[$urandom_range(0, e - 1)];
      end
      run_load(n, 0, n < NUM_IDS);
      model_commit(n);
      tests_run++;
      if (entry_count !== CNT_W'(n) || obs_done != 1 || obs_err != 0) begin
        tests_failed++; $display("FAIL rand_load cnt=%0d done=%0d err=%0d want %0d,1,0",
          entry_count, obs_done, obs_err, n);
      end
      for (int c = 0; c < 6; c++) begin
        h = ($urandom_range(0, 1) == 1) ? model[$urandom_range(0, model_cnt - 1)] : rand_sig();
        ref_lookup(h, ehit, eidx, elat);
        run_cmp(h, got, lat, hit, idx, pa, rdy);
        tests_run++;
        if (!got || lat != elat || hit !== ehit || idx !== eidx || pa !== 1'b0) begin
          tests_failed++; $display("FAIL rand_cmp got=%0d lat=%0d hit=%b idx=%0d after=%b want lat=%0d hit=%b idx=%0d",
            got, lat, hit, idx, pa, elat, ehit, eidx);
        end
      end
      for (int k = 0; k < 3; k++) begin
        r = IDX_W'($urandom_range(0, 15));
        exp_rd = (int'(r) < model_cnt) ? model[r] : '0;
        rd_idx = r;
        @(negedge clk);
        tests_run++;
        if (rd_data !== exp_rd) begin
          tests_failed++; $display("FAIL rand_rd idx=%0d got %h want %h", r, rd_data, exp_rd);
        end
      end
    end
  endtask

  task automatic test_early_end();
    bit got; int lat; logic hit, pa, rdy; logic [IDX_W-1:0] idx;
    for (int e = 0; e < NUM_IDS; e++) ld_vals[e] = rand_sig();
    run_load(3, 5, 1'b1);
    model_commit(3);
    tests_run++;
    if (obs_err != 1 || obs_done != 1 || obs_err_step != obs_done_step || obs_gap != 1) begin
      tests_failed++; $display("FAIL early_end err=%0d done=%0d err_at=%0d done_at=%0d gap=%0d want 1,1,same,1",
        obs_err, obs_done, obs_err_step, obs_done_step, obs_gap);
    end
    tests_run++;
    if (entry_count !== CNT_W'(3)) begin tests_failed++; $display("FAIL early_cnt got %0d want 3", entry_count); end
    rd_idx = 4'd3;
    @(negedge clk);
    tests_run++;
    if (rd_data !== '0) begin tests_failed++; $display("FAIL early_rd3 got %h want 0", rd_data); end
    run_cmp(model[2], got, lat, hit, idx, pa, rdy);
    tests_run++;
    if (!got || lat != 3 || hit !== 1'b1 || idx !== 4'd2) begin
      tests_failed++; $display("FAIL early_cmp got=%0d lat=%0d hit=%b idx=%0d want 1,3,1,2", got, lat, hit, idx);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit got; int lat, mv; logic hit, pa, rdy; logic [IDX_W-1:0] idx;
    for (int e = 0; e < NUM_IDS; e++) ld_vals[e] = rand_sig();
    run_load(NUM_IDS, 0, 1'b0);
    model_commit(NUM_IDS);
    @(negedge clk); cmp_valid = 1'b1; cmp_hash = MISS_HASH;
    @(negedge clk); cmp_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_cnt = 0;
    mv = match_valid;
    repeat (12) begin @(negedge clk); mv += match_valid; end
    tests_run++;
    if (mv != 0 || entry_count !== '0 || load_busy !== 1'b0) begin
      tests_failed++; $display("FAIL rst_scan mv=%0d cnt=%0d busy=%b want 0,0,0", mv, entry_count, load_busy);
    end
    cmp_valid = 1'b1; cmp_hash = MISS_HASH;
    #1 rdy = cmp_ready;
    mv = 0;
    repeat (4) begin @(negedge clk); mv += match_valid; end
    cmp_valid = 1'b0;
    tests_run++;
    if (rdy !== 1'b0 || mv != 0) begin
      tests_failed++; $display("FAIL idle_cmp rdy=%b mv=%0d want 0,0", rdy, mv);
    end
    run_load(0, 0, 1'b1);
    tests_run++;
    if (obs_done != 1 || obs_err != 0 || entry_count !== '0) begin
      tests_failed++; $display("FAIL empty_load done=%0d err=%0d cnt=%0d want 1,0,0", obs_done, obs_err, entry_count);
    end
    run_cmp(rand_sig(), got, lat, hit, idx, pa, rdy);
    tests_run++;
    if (!got || lat != 1 || hit !== 1'b0 || idx !== '0 || rdy !== 1'b1) begin
      tests_failed++; $display("FAIL empty_cmp got=%0d lat=%0d hit=%b idx=%0d rdy=%b want 1,1,0,0,1", got, lat, hit, idx, rdy);
    end
  endtask

  task automatic test_slice_outside_load();
    bit got; int lat; logic hit, pa, rdy; logic [IDX_W-1:0] idx;
    logic e1, e2;
    for (int e = 0; e < NUM_IDS; e++) ld_vals[e] = rand_sig();
    run_load(4, 0, 1'b1);
    model_commit(4);
    @(negedge clk); slice_valid = 1'b1; slice_data = 16'hbeef;
    @(negedge clk); slice_valid = 1'b0; e1 = err;
    @(negedge clk); e2 = err;
    tests_run++;
    if (e1 !== 1'b1 || e2 !== 1'b0 || entry_count !== CNT_W'(4)) begin
      tests_failed++; $display("FAIL stray_slice err=%b,%b cnt=%0d want 1,0,4", e1, e2, entry_count);
    end
    for (int k = 0; k < 4; k++) begin
      rd_idx = IDX_W'(k);
      @(negedge clk);
      tests_run++;
      if (rd_data !== model[k]) begin tests_failed++; $display("FAIL stray_rd%0d got %h want %h", k, rd_data, model[k]); end
    end
    run_cmp(model[3], got, lat, hit, idx, pa, rdy);
    tests_run++;
    if (!got || lat != 4 || hit !== 1'b1 || idx !== 4'd3) begin
      tests_failed++; $display("FAIL stray_cmp got=%0d lat=%0d hit=%b idx=%0d want 1,4,1,3", got, lat, hit, idx);
    end
  endtask

  task automatic test_load_start_priority();
    logic rdy; int mv;
    @(negedge clk); load_start = 1'b1; cmp_valid = 1'b1; cmp_hash = model[0];
    #1 rdy = cmp_ready;
    @(negedge clk); load_start = 1'b0; cmp_valid = 1'b0;
    model_cnt = 0;
    tests_run++;
    if (rdy !== 1'b0 || load_busy !== 1'b1 || entry_count !== '0) begin
      tests_failed++; $display("FAIL ls_priority rdy=%b busy=%b cnt=%0d want 0,1,0", rdy, load_busy, entry_count);
    end
    mv = 0;
    repeat (6) begin @(negedge clk); mv += match_valid; end
    load_end = 1'b1;
    @(negedge clk); load_end = 1'b0;
    rd_idx = '0;
    @(negedge clk); mv += match_valid;
    tests_run++;
    if (mv != 0 || load_busy !== 1'b0 || rd_data !== '0) begin
      tests_failed++; $display("FAIL ls_no_consume mv=%0d busy=%b rd=%h want 0,0,0", mv, load_busy, rd_data);
    end
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_end = 1'b0; slice_valid = 1'b0;
    slice_data = '0; cmp_valid = 1'b0; cmp_hash = '0; rd_idx = '0;
    test_reset();
    test_full_load();
    test_cmp_hit_miss();
    test_duplicates();
    test_early_end();
    test_random();
    test_reset_mid_scan();
    test_slice_outside_load();
    test_load_start_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ipid_sig_store_cmp.md
Name: ipid_sig_store_cmp

Overview:
- Parametrised IP-ID signature store and hash comparator for the SENTRY security controller.
- Assembles NUM_IDS signatures of SIG_W bits from SLICE_W-bit GPIO slices and holds them in a register store.
- Serves indexed readback to the encryption path.
- Runs a sequential one-entry-per-cycle scan of an incoming hash against the store; reports hit/miss and the matching index.
- Generalises the fixed 10 x 256-bit, 16-bit-slice load-and-compare path of the eop2 FSM. Adds early load termination, protocol error reporting and a ready/valid compare handshake.

Parameters:
- NUM_IDS, 10, number of signature entries (>=1).
- SIG_W, 256, signature/hash width in bits.
- SLICE_W, 16, GPIO slice width; SIG_W % SLICE_W must be 0. SPS = SIG_W/SLICE_W slices per entry.
- Derived: IDX_W = max(1, clog2(NUM_IDS)); CNT_W = clog2(NUM_IDS+1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  begin (or restart) the load sequence.
- load_end  in  1  terminate the load early.
- slice_valid  in  1  slice_data is valid this cycle.
- slice_data  in  SLICE_W  signature slice; the first slice of an entry lands in the MSBs.
- load_busy  out  1  high while in LOAD.
- load_done  out  1  one-cycle pulse when the load completes.
- entry_count  out  CNT_W  number of committed entries.
- cmp_valid  in  1  compare request.
- cmp_hash  in  SIG_W  hash to look up.
- cmp_ready  out  1  combinational: (state==READY) && !load_start.
- match_valid  out  1  one-cycle result pulse.
- match_hit  out  1  result: hash found.
- match_idx  out  IDX_W  index of the lowest matching entry; 0 on miss.
- rd_idx  in  IDX_W  readback index.
- rd_data  out  SIG_W  registered readback; 0 if rd_idx >= entry_count.
- err  out  1  one-cycle protocol-error pulse.

Behaviour:
- Reset (rst high at an edge): state=IDLE; entry_count=0; slice_cnt=0; assembly register=0; all outputs 0. Store contents are don't-care because entry_count=0 masks them. Reset overrides any operation in progress.
- States: IDLE, LOAD, READY, CMP.
- IDLE/READY + load_start -> LOAD.
  - entry_count=0, slice_cnt=0, load_busy=1 from the next cycle.
  - load_start has priority over cmp_valid in the same cycle, so cmp_ready is low and nothing is consumed.
- LOAD + slice_valid: assembly <= {assembly[SIG_W-SLICE_W-1:0], slice_data}; slice_cnt++.
  - On the SPS-th slice: store[entry_count] <= completed value; entry_count++; slice_cnt=0.
  - When entry_count reaches NUM_IDS: load_done pulses on the next cycle; state goes to READY.
- LOAD + load_end (load_end wins over slice_valid in the same cycle):
  - slice_cnt==0: clean stop, load_done pulse, go to READY.
  - slice_cnt!=0: the partial entry is discarded, err and load_done both pulse, go to READY.
- LOAD + load_start restarts the load (entry_count=0, slice_cnt=0).
- slice_valid outside LOAD: ignored, err pulse.
- Compare accept: cmp_valid && cmp_ready at edge E0 latches cmp_hash, sets scan idx=0, state goes to CMP.
  - Each CMP cycle compares store[idx] to the latched hash.
  - Hit at idx k: at the next edge match_valid=1, match_hit=1, match_idx=k, state goes to READY. Latency is k+1 cycles after E0.
  - Miss: raised when idx==entry_count-1 fails, or immediately if entry_count==0. Gives match_valid=1, match_hit=0, match_idx=0, latency max(entry_count,1) cycles.
  - Duplicate entries: the lowest index is reported.
- cmp_valid while not ready: held off (not an error), no state change.
- A load_start arriving during CMP is ignored.
- IDLE + cmp_valid is not accepted until the first load completes.
- rd_data <= (rd_idx < entry_count) ? store[rd_idx] : 0 every cycle, in any state, with 1-cycle latency.
- match_hit and match_idx hold their values until the next result; match_valid is a strict pulse.

Test Plan:
- Load 10 full entries (slice s of entry e = {e[7:0], s[7:0]}) -> load_done pulses once after the 160th slice; entry_count=10; rd_idx=3 gives rd_data=0x0300_0301_..._030F one cycle later.
- Compare against entry 7's value -> match_valid 8 cycles after accept; hit=1, idx=7.
- Compare 0xaa12953e...085ecd (not stored) -> match_valid after 10 cycles; hit=0, idx=0. Store two identical entries at 2 and 5 -> idx=2.
- Restart the load, commit 3 entries plus 5 slices, then load_end -> err and load_done pulse together; entry_count=3; rd_idx=3 reads 0; compare entry 2 hits idx=2 after 3 cycles.
- Assert rst at cycle 4 of a compare scan -> no match_valid; entry_count=0. Then cmp_valid in IDLE -> not accepted. Load 0 entries via load_start plus immediate load_end, then compare -> miss after 1 cycle.
- slice_valid in READY -> err pulse, store unchanged. load_start together with cmp_valid -> cmp_ready=0, compare not consumed, state=LOAD.
